reg_dump_streamer: RTL
======================

REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 SHALL take parameter NREGS, default 4: number of vector registers (A1..A4).
REQ-002 SHALL take parameter LANES, default 16: 32-bit lanes per register.
REQ-003 SHALL take parameter LANE_W, default 32: lane and output word width in bits.
REQ-004 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: regs  in  NREGS*LANES*LANE_W (2048)  packed CPU register file {A1,A2,A3,A4}, A1 in the MSBs.
REQ-007 SHALL have ports: cc  in  32  CPU condition-code vector.
REQ-008 SHALL have ports: snap_req  in  1  single-cycle request to snapshot regs and cc.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  LANE_W; out_last  out  1: valid/ready word stream.
REQ-010 SHALL have ports: busy  out  1  snapshot held or streaming; drop_cnt  out  8  rejected requests.

Function
REQ-011 Snapshot: snap_req sampled high in IDLE SHALL copy regs and cc into a shadow register on that edge; later changes to regs/cc SHALL NOT affect the stream.
REQ-012 Word order SHALL be: A1 lane0..lane15, A2, A3, A4, then cc. Word k (k<64) = regs[2047-32k -: 32]. Lane0 is the MSB lane. Total 65 words without header.
REQ-013 FSM states SHALL be IDLE, HDR (macro only), STREAM. IDLE->STREAM (or HDR) on accepted snap_req. HDR->STREAM on handshake. STREAM->IDLE on handshake of the last word.
REQ-014 Latency: out_valid SHALL be high in the cycle after the accepting edge, presenting the first word.
REQ-015 A word transfers when out_valid && out_ready at a rising edge. While out_valid && !out_ready, out_data and out_last SHALL hold stable.
REQ-016 out_last SHALL be high only with the cc word.
REQ-017 Word index SHALL be a 7-bit counter that resets to 0 on each new snapshot and never wraps mid-stream.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 snap_req while busy SHALL be dropped and SHALL increment drop_cnt, saturating at 255. Exception: snap_req on the same edge as the final handshake SHALL be accepted, with back-to-back streaming and no idle cycle.
REQ-020 out_ready high while out_valid low SHALL have no effect.

Reset
REQ-021 reset_n low SHALL force, asynchronously: state=IDLE, out_valid=0, out_last=0, out_data=0, busy=0, drop_cnt=0, word index=0, shadow=0, header sequence=0.
REQ-022 Reset mid-stream SHALL abandon the snapshot. After release, no word is emitted until a new snap_req.

Configuration
REQ-023 Macro DUMP_HEADER_EN defined: each snapshot SHALL begin with a header word {8'hA5, 8'h00, seq[15:0]}, for a total of 66 words. seq SHALL start at 0 and increment by 1 per accepted snapshot, wrapping 0xFFFF->0.
REQ-024 Macro DUMP_HEADER_EN undefined: the HDR state and seq counter SHALL be absent, and the stream SHALL be exactly 65 words.

Structure
REQ-025 Shared package dsd_vec_pkg SHALL hold NREGS, LANES, LANE_W, REG_W (=LANES*LANE_W), DUMP_WORDS (=NREGS*LANES+1), the header magic 8'hA5, and the FSM state enum.
REQ-026 Sub-module dump_word_sel SHALL implement the combinational shadow-plus-index to 32-bit word selection. The FSM, counters and handshake SHALL stay in reg_dump_streamer.

Verification
REQ-027 Basic: regs word k = 32'h1000_0000+k, cc=32'h5; pulse snap_req with out_ready=1 -> 65 consecutive words 1000_0000..1000_003F, then 0000_0005 with out_last=1; busy drops the next cycle.
REQ-028 Backpressure: toggle out_ready 1/0 every cycle -> same 65 values, each held stable while stalled; no word duplicated or skipped.
REQ-029 Snapshot isolation: change regs to all 32'hFFFF_FFFF one cycle after snap_req -> streamed values are unchanged from the snapshot.
REQ-030 Drop/back-to-back: pulse snap_req 3 times mid-stream -> drop_cnt=3. Pulse it on the last-handshake edge -> second stream starts the next cycle and drop_cnt stays 3.
REQ-031 Reset mid-stream: assert reset_n=0 at word 20 -> out_valid=0, drop_cnt=0 immediately (asynchronous); after release, no output until a new snap_req.
REQ-032 DUMP_HEADER_EN: two snapshots -> headers 32'hA500_0000 then 32'hA500_0001, each followed by 65 words.

Source files
------------

// File: rtl/dsd_vec_pkg.sv
// Shared constants, FSM state enum and header-word helper for the register dump streamer.
// Header support is compiled in when DUMP_HEADER_EN is defined.
package dsd_vec_pkg;

    localparam int unsigned NREGS      = 4;
    localparam int unsigned LANES      = 16;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned REG_W      = LANES * LANE_W;
    localparam int unsigned DUMP_WORDS = NREGS * LANES + 1;
    localparam int unsigned IDX_W      = 7;
    localparam int unsigned CC_W       = 32;
    localparam int unsigned SEQ_W      = 16;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

`ifdef DUMP_HEADER_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_STREAM = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd2
    } state_e;
`endif

    // Header word: magic, reserved byte, snapshot sequence number.
    function automatic logic [31:0] hdr_word(input logic [SEQ_W-1:0] seq);
        return {HDR_MAGIC, 8'h00, seq};
    endfunction

endpackage

// File: rtl/dump_word_sel.sv
// Combinational word picker: maps a dump index onto a register lane, or the cc word
// after the last lane. Out-of-range indices return zero.
module dump_word_sel #(
    parameter int unsigned NREGS  = dsd_vec_pkg::NREGS,
    parameter int unsigned LANES  = dsd_vec_pkg::LANES,
    parameter int unsigned LANE_W = dsd_vec_pkg::LANE_W
) (
    input  logic [NREGS*LANES*LANE_W-1:0] regs,
    input  logic [dsd_vec_pkg::CC_W-1:0]  cc,
    input  logic [dsd_vec_pkg::IDX_W-1:0] idx,
    output logic [LANE_W-1:0]             word_c
);
    import dsd_vec_pkg::*;

    localparam int unsigned NVEC   = NREGS * LANES;
    localparam int unsigned REGS_W = NVEC * LANE_W;

    logic [LANE_W-1:0] words [NVEC+1];

    // Word 0 is the most significant lane of A1.
    for (genvar g = 0; g < int'(NVEC); g++) begin : g_lane
        assign words[g] = regs[REGS_W-1-LANE_W*g -: LANE_W];
    end

    assign words[NVEC] = LANE_W'(cc);

    always_comb begin
        word_c = '0;
        if (idx <= IDX_W'(NVEC)) begin
            word_c = words[idx];
        end
    end

endmodule

// File: rtl/reg_dump_streamer.sv
// Snapshots the vector register file and cc, then streams them as words over valid/ready.
// Defining DUMP_HEADER_EN prepends a sequence-numbered header word to every snapshot.
module reg_dump_streamer #(
    parameter int unsigned NREGS  = dsd_vec_pkg::NREGS,
    parameter int unsigned LANES  = dsd_vec_pkg::LANES,
    parameter int unsigned LANE_W = dsd_vec_pkg::LANE_W
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NREGS*LANES*LANE_W-1:0] regs,
    input  logic [31:0]                   cc,
    input  logic                          snap_req,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANE_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic [7:0]                    drop_cnt
);
    import dsd_vec_pkg::*;

    localparam int unsigned NVEC   = NREGS * LANES;
    localparam int unsigned REGS_W = NVEC * LANE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVEC);

    state_e             state_q;
    logic [REGS_W-1:0]  snap_regs_q;
    logic [CC_W-1:0]    snap_cc_q;
    logic [IDX_W-1:0]   idx_q;
`ifdef DUMP_HEADER_EN
    logic [SEQ_W-1:0]   seq_q;
`endif

    logic               hs_c;
    logic               final_hs_c;
    logic               accept_c;
    logic               drop_c;
    logic [REGS_W-1:0]  sel_regs_c;
    logic [CC_W-1:0]    sel_cc_c;
    logic [IDX_W-1:0]   sel_idx_c;
    logic [LANE_W-1:0]  word_c;
    logic [IDX_W-1:0]   idx_inc_c;

    // Handshake decode; a request on the final handshake starts the next dump directly.
    always_comb begin
        hs_c       = out_valid & out_ready;
        final_hs_c = (state_q == ST_STREAM) & hs_c & out_last;
        accept_c   = snap_req & ((state_q == ST_IDLE) | final_hs_c);
        drop_c     = snap_req & ~accept_c;
        idx_inc_c  = idx_q + IDX_W'(1);
    end

    // The first word must come straight from the live inputs on the accepting edge.
    always_comb begin
        sel_regs_c = snap_regs_q;
        sel_cc_c   = snap_cc_q;
        sel_idx_c  = idx_inc_c;
        if (accept_c) begin
            sel_regs_c = regs;
            sel_cc_c   = cc;
            sel_idx_c  = '0;
        end
`ifdef DUMP_HEADER_EN
        else if (state_q == ST_HDR) begin
            sel_idx_c = '0;
        end
`endif
    end

    dump_word_sel #(
        .NREGS  (NREGS),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_word_sel (
        .regs   (sel_regs_c),
        .cc     (sel_cc_c),
        .idx    (sel_idx_c),
        .word_c (word_c)
    );

    // Drop counter saturates so a stuck requester cannot wrap it back to a small value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (drop_c && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Dump FSM with registered stream outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            idx_q       <= '0;
            snap_regs_q <= '0;
            snap_cc_q   <= '0;
`ifdef DUMP_HEADER_EN
            seq_q       <= '0;
`endif
        end else if (accept_c) begin
            snap_regs_q <= regs;
            snap_cc_q   <= cc;
            idx_q       <= '0;
            out_valid   <= 1'b1;
            out_last    <= 1'b0;
            busy        <= 1'b1;
`ifdef DUMP_HEADER_EN
            state_q     <= ST_HDR;
            out_data    <= LANE_W'(hdr_word(seq_q));
            seq_q       <= seq_q + SEQ_W'(1);
`else
            state_q     <= ST_STREAM;
            out_data    <= word_c;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
`ifdef DUMP_HEADER_EN
                ST_HDR: begin
                    if (hs_c) begin
                        state_q  <= ST_STREAM;
                        out_data <= word_c;
                        out_last <= 1'b0;
                    end
                end
`endif
                ST_STREAM: begin
                    if (hs_c) begin
                        if (out_last) begin
                            state_q   <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            idx_q    <= idx_inc_c;
                            out_data <= word_c;
                            out_last <= (idx_inc_c == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
